// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Opcode map and FSM state encoding shared by the multi-cycle ALU
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

    // 4-bit opcode map; opcodes 5..9 are aliases of ADD
    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SHL    = 4'd1;
    localparam logic [3:0] OP_SHR    = 4'd2;
    localparam logic [3:0] OP_OR     = 4'd3;
    localparam logic [3:0] OP_AND    = 4'd4;
    localparam logic [3:0] OP_CMPEQ0 = 4'd10;
    localparam logic [3:0] OP_CMPEQ1 = 4'd11;
    localparam logic [3:0] OP_MFHI   = 4'd12;
    localparam logic [3:0] OP_MUL    = 4'd13;
    localparam logic [3:0] OP_MFLO   = 4'd14;
    localparam logic [3:0] OP_SUB    = 4'd15;

    // Control FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/mul_iter.sv
`default_nettype none
// ============================================================================
//  Module   : mul_iter
//  Purpose  : Iterative unsigned shift-add multiplier, one multiplier bit per
//             cycle. Operands load on start; WIDTH iterations follow.
//             'done' is high during the final iteration cycle and 'product'
//             then carries the value the accumulator takes at that edge.
//  Revision : 1.0  initial release
// ============================================================================
module mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic              r_busy;
    logic [CW-1:0]     r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]  r_mplier;
    logic [2*WIDTH-1:0] w_acc_next;

    // Conditionally add the shifted multiplicand for the current multiplier bit
    always_comb begin
        w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    end

    assign busy    = r_busy;
    assign done    = r_busy && (r_cnt == CW'(1));
    assign product = w_acc_next;

    // Load operands on start, then step one multiplier bit per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (start) begin
            r_busy   <= 1'b1;
            r_cnt    <= CW'(WIDTH);
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule : mul_iter
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mc
//  Purpose  : Multi-cycle ALU with valid/ready handshakes, registered result
//             and flags, iterative multiplier and persistent HI/LO registers.
//  Revision : 1.0  initial release
// ============================================================================
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag,
    output logic             neg_flag,
    output logic             overflow_flag
);

    // Shift amount bits taken from B; derived from WIDTH, never overridden
    localparam int SHW = $clog2(WIDTH);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_neg;
    logic               r_ovf;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_accept;
    logic               w_is_mul;
    logic               w_mul_busy;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_product;
    logic [WIDTH-1:0]   w_add;
    logic [WIDTH-1:0]   w_sub;
    logic               w_shift_oob;
    logic [WIDTH-1:0]   w_res;
    logic               w_ovf;

    // Handshake: multiply busy keeps the input closed for the whole MUL phase
    assign in_ready  = ((r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready))
                       && !w_mul_busy;
    assign w_accept  = in_valid && in_ready;
    assign w_is_mul  = (opcode == OP_MUL);
    assign out_valid = (r_state == ST_DONE);

    assign result        = r_result;
    assign zero_flag     = r_zero;
    assign neg_flag      = r_neg;
    assign overflow_flag = r_ovf;

    mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_accept && w_is_mul),
        .a       (a),
        .b       (b),
        .busy    (w_mul_busy),
        .done    (w_mul_done),
        .product (w_product)
    );

    assign w_add = a + b;
    assign w_sub = a - b;
    // Any shift amount of WIDTH or more clears the result; compared in a wide
    // domain so non-power-of-two widths are handled too
    assign w_shift_oob = ({32'd0, b} >= {{WIDTH{1'b0}}, 32'(WIDTH)});

    // Single-cycle datapath evaluated on the operands presented at acceptance
    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        case (opcode)
            OP_SHL:    w_res = w_shift_oob ? '0 : (a << b[SHW-1:0]);
            OP_SHR:    w_res = w_shift_oob ? '0 : (a >> b[SHW-1:0]);
            OP_OR:     w_res = a | b;
            OP_AND:    w_res = a & b;
            OP_CMPEQ0,
            OP_CMPEQ1: w_res = (a == b) ? '0 : WIDTH'(1);
            OP_MFHI:   w_res = r_hi;
            OP_MFLO:   w_res = r_lo;
            OP_MUL:    w_res = '0;
            OP_SUB: begin
                w_res = w_sub;
                w_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
            end
            default: begin  // ADD and its aliases 5..9
                w_res = w_add;
                w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_is_mul ? ST_MUL : ST_DONE;
                end
            end
            ST_MUL: begin
                if (w_mul_done) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (w_accept) begin
                    w_state_next = w_is_mul ? ST_MUL : ST_DONE;
                end else if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Result, flags and HI/LO: updated only at DONE entry, held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_zero   <= 1'b0;
            r_neg    <= 1'b0;
            r_ovf    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else if (w_mul_done) begin
            r_hi     <= w_product[2*WIDTH-1:WIDTH];
            r_lo     <= w_product[WIDTH-1:0];
            r_result <= w_product[WIDTH-1:0];
            r_zero   <= (w_product[WIDTH-1:0] == '0);
            r_neg    <= w_product[WIDTH-1];
            r_ovf    <= |w_product[2*WIDTH-1:WIDTH];
        end else if (w_accept && !w_is_mul) begin
            r_result <= w_res;
            r_zero   <= (w_res == '0);
            r_neg    <= w_res[WIDTH-1];
            r_ovf    <= w_ovf;
        end
    end

endmodule : alu_mc
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_mc
//  Purpose  : Self-checking bench for alu_mc (WIDTH = 16) with an in-order
//             scoreboard fed from an independent reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_mc;
    import alu_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [3:0]   opcode = 4'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] result;
    logic         zero_flag;
    logic         neg_flag;
    logic         overflow_flag;

    typedef struct packed {
        logic [15:0] res;
        logic        z;
        logic        n;
        logic        v;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          checks = 0;
    int          failures = 0;
    int          n_xfer = 0;
    logic [15:0] m_hi = '0;
    logic [15:0] m_lo = '0;

    alu_mc #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .opcode        (opcode),
        .a             (a),
        .b             (b),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .zero_flag     (zero_flag),
        .neg_flag      (neg_flag),
        .overflow_flag (overflow_flag)
    );

    always #5 clk = ~clk;

    // Reference model; MUL updates the model HI/LO at issue time
    function automatic exp_t model(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
        exp_t        e;
        int          sx;
        int          sy;
        int          s;
        logic [31:0] p;
        e  = '0;
        sx = int'($signed(x));
        sy = int'($signed(y));
        case (op)
            4'd1:        e.res = x << y;
            4'd2:        e.res = x >> y;
            4'd3:        e.res = x | y;
            4'd4:        e.res = x & y;
            4'd10, 4'd11: e.res = (x == y) ? 16'd0 : 16'd1;
            4'd12:       e.res = m_hi;
            4'd14:       e.res = m_lo;
            4'd13: begin
                p     = 32'(x) * 32'(y);
                m_hi  = p[31:16];
                m_lo  = p[15:0];
                e.res = p[15:0];
                e.v   = (p > 32'h0000_FFFF);
            end
            4'd15: begin
                s     = sx - sy;
                e.res = x - y;
                e.v   = (s > 32767) || (s < -32768);
            end
            default: begin
                s     = sx + sy;
                e.res = x + y;
                e.v   = (s > 32767) || (s < -32768);
            end
        endcase
        e.z = (e.res == 16'd0);
        e.n = e.res[15];
        return e;
    endfunction

    // Scoreboard: compare each transferred result against the oldest expectation
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            n_xfer++;
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected got result=%h z=%b n=%b v=%b", result, zero_flag, neg_flag, overflow_flag);
            end else begin
                mon_e = sbq.pop_front();
                if ({result, zero_flag, neg_flag, overflow_flag} !== mon_e) begin
                    failures++;
                    $display("FAIL sb_result got res=%h z=%b n=%b v=%b expected res=%h z=%b n=%b v=%b",
                             result, zero_flag, neg_flag, overflow_flag, mon_e.res, mon_e.z, mon_e.n, mon_e.v);
                end
            end
        end
    end

    // Present an op, wait for acceptance; returns #1 after the accepting edge with in_valid still high
    task automatic issue(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y, output int waits);
        opcode   = op;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        sbq.push_back(model(op, x, y));
        waits = 0;
        forever begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            waits++;
            if (waits >= 200) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout op=%0d in_ready=%b required 1", op, in_ready);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k = 0;
        while (sbq.size() != 0 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d required 0", sbq.size());
        end
    endtask

    task automatic test_reset();
        #2;
        checks++; if (in_ready !== 1'b1)      begin failures++; $display("FAIL rst_in_ready got %b required 1", in_ready); end
        checks++; if (out_valid !== 1'b0)     begin failures++; $display("FAIL rst_out_valid got %b required 0", out_valid); end
        checks++; if (result !== 16'h0)       begin failures++; $display("FAIL rst_result got %h required 0000", result); end
        checks++; if ({zero_flag, neg_flag, overflow_flag} !== 3'b000)
                                              begin failures++; $display("FAIL rst_flags got %b required 000", {zero_flag, neg_flag, overflow_flag}); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_add_sub();
        int w;
        out_ready = 1'b1;
        issue(OP_ADD, 16'h7FFF, 16'h0001, w);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL add_latency out_valid got %b required 1", out_valid); end
        drain();
        issue(OP_SUB, 16'h0005, 16'h0005, w);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL sub_latency out_valid got %b required 1", out_valid); end
        drain();
        issue(4'd7, 16'h1234, 16'h1111, w);  // ADD alias
        in_valid = 1'b0;
        drain();
    endtask

    task automatic test_mul();
        int w;
        int k;
        out_ready = 1'b1;
        issue(OP_MUL, 16'hFFFF, 16'h0002, w);
        in_valid = 1'b0;
        k = 0;
        while (k < 40) begin
            checks++;
            if (in_ready !== 1'b0) begin failures++; $display("FAIL mul_in_ready cycle=%0d got %b required 0", k, in_ready); end
            @(posedge clk);
            #1;
            k++;
            if (out_valid === 1'b1) break;
        end
        checks++; if (k != 16) begin failures++; $display("FAIL mul_latency got %0d cycles required 16", k); end
        issue(OP_MFHI, 16'h0000, 16'h0000, w);
        issue(OP_MFLO, 16'h0000, 16'h0000, w);
        in_valid = 1'b0;
        drain();
    endtask

    task automatic test_shifts();
        int w;
        out_ready = 1'b1;
        issue(OP_SHL, 16'h0001, 16'd15, w);   in_valid = 1'b0; drain();
        issue(OP_SHL, 16'h0001, 16'd16, w);   in_valid = 1'b0; drain();
        issue(OP_SHR, 16'h8000, 16'd3, w);    in_valid = 1'b0; drain();
        issue(OP_CMPEQ0, 16'h00AA, 16'h00AA, w); in_valid = 1'b0; drain();
        issue(OP_CMPEQ1, 16'h00AA, 16'h00AB, w); in_valid = 1'b0; drain();
    endtask

    task automatic test_backpressure();
        int w;
        int x0;
        out_ready = 1'b0;
        issue(OP_OR, 16'h00F0, 16'h000F, w);
        in_valid = 1'b0;
        opcode   = OP_AND;  // later input changes must not disturb the held result
        a        = 16'h0000;
        x0 = n_xfer;
        repeat (4) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1)  begin failures++; $display("FAIL bp_valid got %b required 1", out_valid); end
            checks++; if (result !== 16'h00FF) begin failures++; $display("FAIL bp_result got %h required 00FF", result); end
            checks++; if (in_ready !== 1'b0)   begin failures++; $display("FAIL bp_in_ready got %b required 0", in_ready); end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (n_xfer != x0 + 1)  begin failures++; $display("FAIL bp_transfers got %0d required %0d", n_xfer - x0, 1); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_after_valid got %b required 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        int w;
        int x0;
        logic [3:0] op;
        out_ready = 1'b1;
        x0 = n_xfer;
        for (int i = 0; i < 8; i++) begin
            op = 4'($urandom_range(0, 15));
            if (op == OP_MUL) op = OP_ADD;
            if (op == OP_SHL || op == OP_SHR)
                issue(op, 16'($urandom), 16'($urandom_range(0, 17)), w);
            else
                issue(op, 16'($urandom), 16'($urandom), w);
            checks++; if (w != 0)            begin failures++; $display("FAIL stream_stall op=%0d got %0d waits required 0", i, w); end
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stream_valid op=%0d got %b required 1", i, out_valid); end
        end
        in_valid = 1'b0;
        drain();
        checks++; if (n_xfer != x0 + 8) begin failures++; $display("FAIL stream_count got %0d required 8", n_xfer - x0); end
    endtask

    task automatic test_reset_mid_mul();
        int w;
        out_ready = 1'b1;
        issue(OP_MUL, 16'h1234, 16'h5678, w);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL mrst_in_ready got %b required 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mrst_out_valid got %b required 0", out_valid); end
        checks++; if (result !== 16'h0)   begin failures++; $display("FAIL mrst_result got %h required 0000", result); end
        checks++; if ({zero_flag, neg_flag, overflow_flag} !== 3'b000)
                                          begin failures++; $display("FAIL mrst_flags got %b required 000", {zero_flag, neg_flag, overflow_flag}); end
        sbq.delete();
        m_hi = 16'h0;
        m_lo = 16'h0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(OP_MFHI, 16'h0000, 16'h0000, w);
        issue(OP_MFLO, 16'h0000, 16'h0000, w);
        in_valid = 1'b0;
        drain();
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mul();
        test_shifts();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mul();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule : tb_alu_mc
`default_nettype wire
